// File: rtl/bin_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Define BIN_TO_BCD_OVF_EN to add the ovf output (result truncated to DIGITS).
module bin_to_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd
`ifdef BIN_TO_BCD_OVF_EN
  ,
  output logic                ovf
`endif
);

  // state | meaning
  // IDLE  | waiting for start
  // SHIFT | one add-3 / shift-left step per cycle, WIDTH cycles
  // DONE  | done pulse, result valid, may accept the next start
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_nxt;
  logic [BW-1:0]    scratch;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    scratch_nxt;
  logic             accept;
  logic             last;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (state == SHIFT) && (cnt == CNT_LAST);
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);

  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // Truncating cast drops the bit leaving the top digit
  assign {scratch_nxt, sh_nxt} = (BW + WIDTH)'({adj, sh, 1'b0});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      sh      <= '0;
      scratch <= '0;
      bcd     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state   <= SHIFT;
            sh      <= bin;
            scratch <= '0;
            cnt     <= '0;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          sh      <= sh_nxt;
          scratch <= scratch_nxt;
          cnt     <= cnt + CW'(1);
          if (last) begin
            state <= DONE;
            bcd   <= scratch_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BIN_TO_BCD_OVF_EN
  logic ovf_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_acc <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      ovf_acc <= 1'b0;
    end else if (state == SHIFT) begin
      ovf_acc <= ovf_acc | adj[BW-1];
      if (last) ovf <= ovf_acc | adj[BW-1];
    end
  end
`endif

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd: vector table plus scoreboard queues,
// with hand-written back-to-back, ignored-start and mid-conversion reset sequences.
module tb_bin_to_bcd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  bin = '0;
  logic        busy, done;
  logic [11:0] bcd;
  logic        start2 = 1'b0;
  logic [7:0]  bin2 = '0;
  logic        busy2, done2;
  logic [7:0]  bcd2;
`ifdef BIN_TO_BCD_OVF_EN
  logic        ovf, ovf2;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  exp2_q[$];
  logic        exp_ovf_q[$];

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
  } vec_t;

  typedef struct {
    logic [7:0] bin;
    logic [7:0] bcd;
    logic       ovf;
  } vec2_t;

  vec_t  vecs[12];
  vec2_t vecs2[5];

  bin_to_bcd #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd)
`ifdef BIN_TO_BCD_OVF_EN
    , .ovf(ovf)
`endif
  );

  bin_to_bcd #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2)
`ifdef BIN_TO_BCD_OVF_EN
    , .ovf(ovf2)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] model3(input int v);
    logic [11:0] r;
    int x;
    x = v;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Scoreboards: pop an expectation on every done pulse
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else check("bcd_result", bcd, exp_q.pop_front());
    end
    if (rst_n && done2) begin
      if (exp2_q.size() == 0) check("unexpected_done2", 32'd1, 32'd0);
      else check("bcd2_result", bcd2, exp2_q.pop_front());
`ifdef BIN_TO_BCD_OVF_EN
      if (exp_ovf_q.size() != 0) check("ovf2_result", ovf2, exp_ovf_q.pop_front());
`endif
    end
  end

  task automatic wait_done(output int t);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
    t = cyc;
  endtask

  task automatic run_one(input logic [7:0] v, input logic [11:0] e);
    int n;
    @(posedge clk); #1;
    bin = v; start = 1'b1; exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; bin = 8'($urandom);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    check("busy_cycles", n, 8);
    check("done_after_busy", done, 1'b1);
  endtask

  task automatic run_two(input logic [7:0] v, input logic [7:0] e, input logic o);
    int n;
    @(posedge clk); #1;
    bin2 = v; start2 = 1'b1; exp2_q.push_back(e); exp_ovf_q.push_back(o);
    @(posedge clk); #1;
    start2 = 1'b0; bin2 = 8'($urandom);
    n = 0;
    while (busy2 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    check("busy2_cycles", n, 8);
    check("done2_after_busy", done2, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t1, t2, n;
    logic held;
    vecs = '{
      '{8'd255, 12'h255}, '{8'd0,   12'h000}, '{8'd1,   12'h001}, '{8'd9,   12'h009},
      '{8'd10,  12'h010}, '{8'd99,  12'h099}, '{8'd100, 12'h100}, '{8'd128, 12'h128},
      '{8'd200, 12'h200}, '{8'd254, 12'h254}, '{8'd5,   12'h005}, '{8'd50,  12'h050}};
    vecs2 = '{
      '{8'd123, 8'h23, 1'b1}, '{8'd45, 8'h45, 1'b0}, '{8'd100, 8'h00, 1'b1},
      '{8'd99,  8'h99, 1'b0}, '{8'd255, 8'h55, 1'b1}};

    repeat (3) @(posedge clk); #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_bcd", bcd, 12'h000);
    check("reset_bcd2", bcd2, 8'h00);

    // Release and request together: accepted on the very next edge
    rst_n = 1'b1; bin = 8'd77; start = 1'b1; exp_q.push_back(12'h077);
    @(posedge clk); #1;
    start = 1'b0;
    check("first_edge_accept", busy, 1'b1);
    wait_done(t1);

    foreach (vecs[i]) run_one(vecs[i].bin, vecs[i].bcd);
    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(0, 255);
      run_one(8'(n), model3(n));
    end

    // Back-to-back with start held high
    @(posedge clk); #1;
    bin = 8'd0; start = 1'b1; exp_q.push_back(12'h000); exp_q.push_back(12'h099);
    @(posedge clk); #1;
    bin = 8'd99;
    wait_done(t1);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_accept_from_done", busy, 1'b1);
    wait_done(t2);
    check("b2b_done_spacing", t2 - t1, 9);

    // Start pulse during SHIFT is ignored; bcd keeps the previous result
    @(posedge clk); #1;
    bin = 8'd200; start = 1'b1; exp_q.push_back(12'h200);
    @(posedge clk); #1;
    start = 1'b0; bin = 8'd7;
    n = 0; held = 1'b1;
    while (busy && n < 40) begin
      start = (n == 2);
      if (bcd !== 12'h099) held = 1'b0;
      n++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("ignored_start_busy_cycles", n, 8);
    check("bcd_held_during_shift", held, 1'b1);
    check("ignored_start_done", done, 1'b1);
    repeat (12) @(posedge clk); #1;
    check("ignored_start_no_restart", busy, 1'b0);

    // Reset in the 4th SHIFT cycle
    @(posedge clk); #1;
    bin = 8'd255; start = 1'b1; exp_q.push_back(12'h255);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0; exp_q.delete();
    #1;
    check("mid_reset_busy", busy, 1'b0);
    check("mid_reset_done", done, 1'b0);
    check("mid_reset_bcd", bcd, 12'h000);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk); #1;
    check("post_reset_idle", busy, 1'b0);
    check("post_reset_bcd", bcd, 12'h000);
    run_one(8'd64, 12'h064);

    // Two-digit instance: truncation to bin mod 100
    foreach (vecs2[i]) run_two(vecs2[i].bin, vecs2[i].bcd, vecs2[i].ovf);

    repeat (4) @(posedge clk); #1;
    check("queue_drained", exp_q.size(), 0);
    check("queue2_drained", exp2_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
